// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for the sync_fifo slice.
// Optional feature macro used by this slice: SYNC_FIFO_PARITY_EN.
package sync_fifo_pkg;

   // Widest data word the parity helper accepts; narrower words are zero-extended.
   localparam int PARITY_MAX_W = 64;

   // Pointer width: address bits plus one wrap bit.
   function automatic int ptr_width(input int addrsize);
      return addrsize + 1;
   endfunction

   // Even-parity bit: makes the total count of ones (data + bit) even.
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: handshake, status and error signals of the sync_fifo.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_if
   import sync_fifo_pkg::*;
#(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
) ();

   logic                             flush;
   logic                             wr_en;
   logic [DATASIZE-1:0]              wdata;
   logic                             rd_en;
   logic [DATASIZE-1:0]              rdata;
   logic                             rvalid;
   logic                             full;
   logic                             empty;
   logic                             almost_full;
   logic                             almost_empty;
   logic [ptr_width(ADDRSIZE)-1:0]   level;
   logic                             overflow;
   logic                             underflow;
   logic                             clr_err;
   logic                             parity_err;

   modport master (
      output flush, wr_en, wdata, rd_en, clr_err,
      input  rdata, rvalid, full, empty, almost_full, almost_empty,
             level, overflow, underflow, parity_err
   );

   modport slave (
      input  flush, wr_en, wdata, rd_en, clr_err,
      output rdata, rvalid, full, empty, almost_full, almost_empty,
             level, overflow, underflow, parity_err
   );

endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port RAM, one write port and a registered read port.
// Storage is not reset; only the read register returns to zero on reset.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int ADDRSIZE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [ADDRSIZE-1:0] waddr,
   input  logic [WIDTH-1:0]    wdata,
   input  logic                re,
   input  logic [ADDRSIZE-1:0] raddr,
   output logic [WIDTH-1:0]    rdata
);

   logic [WIDTH-1:0] mem [0:(1 << ADDRSIZE)-1];

   // Write port: store the word when the controller accepts a write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port: capture the addressed word on an accepted read, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with level count, thresholds, sticky error flags,
// synchronous flush and a 1-cycle registered read port.
// Optional feature macro: SYNC_FIFO_PARITY_EN (stores and checks even parity per word).
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATASIZE  = 8,
   parameter int ADDRSIZE  = 4,
   parameter int AFULL_TH  = (1 << ADDRSIZE) - 2,
   parameter int AEMPTY_TH = 2
) (
   input logic        clk,
   input logic        rst_n,
   sync_fifo_if.slave bus
);

   localparam int PTR_W = ptr_width(ADDRSIZE);
   localparam int DEPTH = 1 << ADDRSIZE;
`ifdef SYNC_FIFO_PARITY_EN
   localparam int MEM_W = DATASIZE + 1;
`else
   localparam int MEM_W = DATASIZE;
`endif

   localparam logic [PTR_W-1:0] DEPTH_LV  = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AFULL_LV  = PTR_W'(AFULL_TH);
   localparam logic [PTR_W-1:0] AEMPTY_LV = PTR_W'(AEMPTY_TH);

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W-1:0] level_q;
   logic [PTR_W-1:0] level_nxt;
   logic             full_q;
   logic             empty_q;
   logic             afull_q;
   logic             aempty_q;
   logic             ovf_q;
   logic             unf_q;
   logic             rvalid_q;
   logic             wr_acc;
   logic             rd_acc;
   logic [MEM_W-1:0] mem_wdata;
   logic [MEM_W-1:0] mem_rdata;

   // Accepts are gated by the registered flags, so a write while full or a
   // read while empty never touches memory or pointers.
   assign wr_acc = bus.wr_en && !full_q  && !bus.flush;
   assign rd_acc = bus.rd_en && !empty_q && !bus.flush;

   // Next fill level from the accepted operations; flush empties the FIFO.
   always_comb begin
      level_nxt = level_q;
      if (bus.flush) begin
         level_nxt = '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level_q + 1'b1;
            2'b01:   level_nxt = level_q - 1'b1;
            default: level_nxt = level_q;
         endcase
      end
   end

   // Pointers: low bits address memory, MSB is the wrap bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (bus.flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_acc) wptr <= wptr + 1'b1;
         if (rd_acc) rptr <= rptr + 1'b1;
      end
   end

   // Level and all level-derived flags are registered from the next level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         level_q  <= level_nxt;
         full_q   <= (level_nxt == DEPTH_LV);
         empty_q  <= (level_nxt == '0);
         afull_q  <= (level_nxt >= AFULL_LV);
         aempty_q <= (level_nxt <= AEMPTY_LV);
      end
   end

   // Sticky error flags: a new event in the same cycle as clr_err wins; flush leaves them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= (ovf_q && !bus.clr_err) || (bus.wr_en && full_q);
         unf_q <= (unf_q && !bus.clr_err) || (bus.rd_en && empty_q);
      end
   end

   // rvalid marks the cycle after an accepted read; flush suppresses the read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rd_acc;
      end
   end

`ifdef SYNC_FIFO_PARITY_EN
   assign mem_wdata      = {even_parity(PARITY_MAX_W'(bus.wdata)), bus.wdata};
   // Check is combinational on the registered word, so it lines up with rvalid.
   assign bus.parity_err = rvalid_q &&
      (even_parity(PARITY_MAX_W'(mem_rdata[DATASIZE-1:0])) != mem_rdata[DATASIZE]);
`else
   assign mem_wdata      = bus.wdata;
   assign bus.parity_err = 1'b0;
`endif

   sync_fifo_mem #(
      .WIDTH    (MEM_W),
      .ADDRSIZE (ADDRSIZE)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (wptr[ADDRSIZE-1:0]),
      .wdata (mem_wdata),
      .re    (rd_acc),
      .raddr (rptr[ADDRSIZE-1:0]),
      .rdata (mem_rdata)
   );

   assign bus.rdata        = mem_rdata[DATASIZE-1:0];
   assign bus.rvalid       = rvalid_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;
   assign bus.level        = level_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;

endmodule
